// File: rtl/aes_engine.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Accepts a block when idle and emits the ciphertext with a one-cycle valid pulse.
module aes_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] blok,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] sifre,
    output logic         c_gecerli
);

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         cur_state, nxt_state;
    logic [127:0] st, rk, new_key, rnd_out;
    logic [3:0]   round;
    logic         accept, last_round;
    logic [31:0]  t_word;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[8*(255 - int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign accept     = (cur_state == IDLE) && g_gecerli;
    assign last_round = (cur_state == RUN) && (round == 4'd10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_state <= IDLE;
        else      cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (g_gecerli) nxt_state = RUN;
            RUN:     if (round == 4'd10) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        hazir = (cur_state == IDLE);
    end

    // Next round key: RotWord/SubWord/Rcon on w3, then the XOR chain across the words.
    always_comb begin
        t_word  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
                  ^ {rcon(round), 24'h000000};
        new_key[127:96] = rk[127:96] ^ t_word;
        new_key[95:64]  = rk[95:64]  ^ new_key[127:96];
        new_key[63:32]  = rk[63:32]  ^ new_key[95:64];
        new_key[31:0]   = rk[31:0]   ^ new_key[63:32];
    end

    // SubBytes and ShiftRows on the column-major state; the last round skips MixColumns.
    always_comb begin
        rnd_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(st[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (round == 4'd10)
                rnd_out[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
            else
                rnd_out[127-32*c -: 32] = mix_column({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
        end
        rnd_out = rnd_out ^ new_key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= '0;
            rk        <= '0;
            round     <= '0;
            sifre     <= '0;
            c_gecerli <= 1'b0;
        end else begin
            c_gecerli <= 1'b0;
            if (accept) begin
                st    <= blok ^ anahtar;
                rk    <= anahtar;
                round <= 4'd1;
            end else if (cur_state == RUN) begin
                st <= rnd_out;
                rk <= new_key;
                if (last_round) begin
                    sifre     <= rnd_out;
                    c_gecerli <= 1'b1;
                    round     <= '0;
                end else begin
                    round <= round + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_engine.sv
// Directed bench for aes_engine: known-answer vectors, back-to-back throughput,
// input changes during a run and an asynchronous reset mid-block.
module tb_aes_engine;

    logic         clk;
    logic         rst;
    logic [127:0] anahtar;
    logic [127:0] blok;
    logic         g_gecerli;
    logic         hazir;
    logic [127:0] sifre;
    logic         c_gecerli;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [4];

    aes_engine dut (
        .clk       (clk),
        .rst       (rst),
        .anahtar   (anahtar),
        .blok      (blok),
        .g_gecerli (g_gecerli),
        .hazir     (hazir),
        .sifre     (sifre),
        .c_gecerli (c_gecerli)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from GF(2^8) arithmetic rather than a lookup table.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] y;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return y;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_calc(tmp[23:16]) ^ rc, sbox_calc(tmp[15:8]),
                       sbox_calc(tmp[7:0]), sbox_calc(tmp[31:24])};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    t[4*c+j] = sbox_calc(s[4*((c+j)%4)+j]);
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r == 10) s[4*c+j] = t[4*c+j];
                    else s[4*c+j] = gmul(t[4*c+j], 8'h02) ^ gmul(t[4*c+(j+1)%4], 8'h03)
                                    ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
                end
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = s[4*c+j] ^ w[4*r+c][31-8*j -: 8];
            end
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Accepts one block, scrambles the inputs while it runs, and checks the completion.
    task automatic apply_stimulus(input string name, input logic [127:0] key,
                                  input logic [127:0] pt, input logic [127:0] ct);
        int cnt;
        logic done = 1'b0;
        @(negedge clk);
        anahtar   = key;
        blok      = pt;
        g_gecerli = 1'b1;
        @(posedge clk);
        #1;
        g_gecerli = 1'b0;
        check_output({name, "_busy"}, 128'(hazir), 128'd0);
        for (cnt = 1; cnt <= 20 && !done; cnt++) begin
            @(posedge clk);
            #1;
            anahtar = {$urandom, $urandom, $urandom, $urandom};
            blok    = {$urandom, $urandom, $urandom, $urandom};
            if (c_gecerli) done = 1'b1;
        end
        check_output({name, "_latency"}, 128'(cnt - 1), 128'd10);
        check_output({name, "_sifre"}, sifre, ct);
        check_output({name, "_hazir"}, 128'(hazir), 128'd1);
        @(posedge clk);
        #1;
        check_output({name, "_pulse_end"}, 128'(c_gecerli), 128'd0);
        check_output({name, "_sifre_hold"}, sifre, ct);
    endtask

    initial begin
        int pulses;
        int low_cnt;
        int prev;
        int stray;
        logic [127:0] exp3;

        vecs[0] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{"appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{"zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{"text", 128'h657870616e642033322d62797465206b,
                    128'h717765727479756f7061736466676820, 128'h0};
        exp3       = aes_model(vecs[3].key, vecs[3].pt);
        vecs[3].ct = exp3;

        rst = 1'b0; g_gecerli = 1'b0; anahtar = '0; blok = '0;
        #3;
        check_output("rst_hazir", 128'(hazir), 128'd1);
        check_output("rst_cg", 128'(c_gecerli), 128'd0);
        check_output("rst_sifre", sifre, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (c_gecerli || !hazir) stray++;
        end
        check_output("idle_stray", 128'(stray), 128'd0);
        check_output("idle_sifre", sifre, 128'd0);

        for (int i = 0; i < 4; i++)
            apply_stimulus(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct);

        // Back-to-back blocks with valid held high.
        @(negedge clk);
        anahtar = vecs[3].key; blok = vecs[3].pt; g_gecerli = 1'b1;
        pulses = 0; low_cnt = 0; prev = 0;
        for (int e = 1; e <= 44; e++) begin
            @(posedge clk);
            #1;
            if (!hazir) low_cnt++;
            if (c_gecerli) begin
                pulses++;
                check_output("tp_spacing", 128'(e - prev), 128'd11);
                check_output("tp_sifre", sifre, exp3);
                prev = e;
            end
        end
        g_gecerli = 1'b0;
        check_output("tp_pulses", 128'(pulses), 128'd4);
        check_output("tp_hazir_low", 128'(low_cnt), 128'd40);

        // Asynchronous reset during round 5 aborts the block.
        @(negedge clk);
        anahtar = vecs[1].key; blok = vecs[1].pt; g_gecerli = 1'b1;
        @(posedge clk);
        #1;
        g_gecerli = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("abort_hazir", 128'(hazir), 128'd1);
        check_output("abort_cg", 128'(c_gecerli), 128'd0);
        check_output("abort_sifre", sifre, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (c_gecerli || !hazir) stray++;
        end
        check_output("abort_no_pulse", 128'(stray), 128'd0);
        apply_stimulus("after_abort", vecs[0].key, vecs[0].pt, vecs[0].ct);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_engine.md
Name: aes_engine

Overview:
Iterative AES-128 encryption core (FIPS-197, encrypt only). It accepts one 128-bit plaintext block and a 128-bit key per transaction. It computes one round per clock with on-the-fly key expansion and presents the 128-bit ciphertext with a one-cycle valid pulse. It sits behind an input FIFO/stream source that drives g_gecerli/blok and in front of a consumer that samples sifre on c_gecerli.

Parameters:
none (AES-128 fixed: 10 rounds, 128-bit key)

Ports:
clk        input   1    system clock, all state updates on rising edge
rst        input   1    reset, asynchronous, active-low (rst=0 resets)
anahtar    input   128  cipher key; byte 0 = anahtar[127:120], byte 15 = anahtar[7:0]
blok       input   128  plaintext block; byte 0 = blok[127:120] (FIPS-197 input order)
g_gecerli  input   1    input valid; block/key accepted when g_gecerli & hazir at a rising edge
hazir      output  1    engine idle and able to accept a block
sifre      output  128  ciphertext, same byte order as blok
c_gecerli  output  1    one-cycle pulse: sifre holds a new ciphertext

Behaviour:
- Reset (rst=0, async): state=IDLE, hazir=1, c_gecerli=0, sifre=0, round counter=0, internal state/key registers=0. Reset mid-operation aborts the block; no c_gecerli is produced for it.
- FSM states: IDLE, RUN.
- IDLE, hazir=1: on an edge with g_gecerli=1, capture state <= blok XOR anahtar (initial AddRoundKey) and roundkey <= anahtar, set round=1, go RUN, hazir=0. anahtar/blok are sampled only at this accept edge; later changes are ignored.
- RUN, one edge per round r=1..10:
  - derive next round key from the current roundkey: RotWord, SubWord, Rcon[r] = 01,02,04,08,10,20,40,80,1B,36; w4=w0^t, w5=w1^w4, w6=w2^w5, w7=w3^w6.
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ newkey for r=1..9; round 10 omits MixColumns.
- At the round-10 edge: sifre <= round-10 result, c_gecerli <= 1, hazir <= 1, state -> IDLE.
- Latency: accept at edge k, c_gecerli=1 for the cycle following edge k+10. c_gecerli is deasserted at the next edge unless another block completes.
- Throughput: with g_gecerli held high, blocks are accepted at edges k, k+11, k+22, … (the accept may coincide with c_gecerli high).
- sifre holds its value until the next completion; it is not cleared when c_gecerli falls.
- g_gecerli while hazir=0 is ignored (no queueing).
- State layout: column-major, byte i at state[127-8i -: 8]. Row r of column c = byte 4c+r. ShiftRows rotates row r left by r.
- MixColumns over GF(2^8), polynomial 0x11B (xtime: shift left, XOR 0x1B on carry).
- S-box: standard AES forward S-box, combinational. 20 lookups per round (16 state + 4 key). Single-cycle combinational round path is required; no pipelining.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, blok 00112233445566778899aabbccddeeff, single g_gecerli pulse -> c_gecerli 10 cycles after accept, sifre=69c4e0d86a7b0430d8cdb78070b4c55a, hazir=1 in the same cycle.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, blok 3243f6a8885a308d313198a2e0370734 -> sifre=3925841d02dc09fbdc118597196a0b32.
- g_gecerli tied 1, key 65787061 6e642033 322d6279 7465206b, blok 71776572 7479756f 70617364 66676820 held constant -> c_gecerli pulses exactly every 11 cycles with an identical sifre each time, matching a software AES-128 model; hazir low exactly 10 cycles per block.
- Change blok/anahtar during RUN (edges k+1..k+10) -> sifre equals the encryption of the values captured at edge k.
- Assert rst=0 asynchronously mid-round (e.g. round 5), release -> immediately hazir=1, c_gecerli=0, sifre=0; no completion pulse for the aborted block; the next accepted block produces the correct result.
- Reset values: hold rst=0 then release with g_gecerli=0 -> hazir=1, c_gecerli=0, sifre=0, remaining idle indefinitely.
